// File: rtl/mii_tx_arbiter.sv
// mii_tx_arbiter: round-robin two-source MII transmit arbiter that frames words with START/TERM.
// It enforces the inter-packet gap, and aborts frames on underrun or oversize with an ERROR word and a flush.
module mii_tx_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int IPG_WORDS  = 2,
    parameter int MAX_WORDS  = 190
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_s0_data,
    input  logic                  i_s0_valid,
    input  logic                  i_s0_last,
    input  logic [DATA_WIDTH-1:0] i_s1_data,
    input  logic                  i_s1_valid,
    input  logic                  i_s1_last,
    output logic                  o_s0_ready,
    output logic                  o_s1_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic [1:0]            o_grant,
    output logic                  o_frame_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] IDLE_D  = {NB{8'h07}};
    localparam logic [DATA_WIDTH-1:0] START_D = {8'hD5, {(NB-2){8'h55}}, 8'hFB};
    localparam logic [DATA_WIDTH-1:0] TERM_D  = {{(NB-1){8'h07}}, 8'hFD};
    localparam logic [DATA_WIDTH-1:0] ERR_D   = {NB{8'hFE}};

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_TERM, S_FLUSH, S_IPG} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [CTRL_WIDTH-1:0] tx_ctrl_q, tx_ctrl_d;
    logic [1:0]            grant_q, grant_d;
    logic                  err_q, err_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic [3:0]            gap_q, gap_d;
    logic                  aborted_q, aborted_d;
    logic                  rr_q, rr_d;
    logic                  ready, sel_valid, sel_last, pick1;
    logic [DATA_WIDTH-1:0] sel_data;

    assign ready      = (state_q == S_DATA) || (state_q == S_FLUSH);
    assign o_s0_ready = ready & grant_q[0];
    assign o_s1_ready = ready & grant_q[1];
    assign sel_valid  = grant_q[1] ? i_s1_valid : i_s0_valid;
    assign sel_last   = grant_q[1] ? i_s1_last : i_s0_last;
    assign sel_data   = grant_q[1] ? i_s1_data : i_s0_data;
    // rr_q set means source 1 wins a tie
    assign pick1      = i_s1_valid & (~i_s0_valid | rr_q);

    always_comb begin
        state_d   = state_q;
        tx_data_d = IDLE_D;
        tx_ctrl_d = '1;
        grant_d   = grant_q;
        err_d     = 1'b0;
        wcnt_d    = wcnt_q;
        gap_d     = gap_q;
        aborted_d = aborted_q;
        rr_d      = rr_q;
        case (state_q)
            S_IDLE: begin
                if (i_s0_valid | i_s1_valid) begin
                    grant_d   = pick1 ? 2'b10 : 2'b01;
                    rr_d      = ~pick1;
                    tx_data_d = START_D;
                    tx_ctrl_d = CTRL_WIDTH'(1);
                    wcnt_d    = '0;
                    aborted_d = 1'b0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                wcnt_d = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
                if (!sel_valid || (!sel_last && wcnt_q == 8'(MAX_WORDS - 1))) begin
                    wcnt_d    = sel_valid ? wcnt_d : wcnt_q;
                    tx_data_d = ERR_D;
                    err_d     = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_TERM;
                end else begin
                    tx_data_d = sel_data;
                    tx_ctrl_d = '0;
                    state_d   = sel_last ? S_TERM : S_DATA;
                end
            end
            S_TERM: begin
                tx_data_d = TERM_D;
                gap_d     = 4'(IPG_WORDS);
                state_d   = aborted_q ? S_FLUSH : S_IPG;
            end
            S_FLUSH: begin
                if (sel_valid && sel_last) begin
                    gap_d   = 4'(IPG_WORDS - 1);
                    state_d = S_IPG;
                end
            end
            S_IPG: begin
                gap_d = (gap_q == 4'd0) ? gap_q : gap_q - 4'd1;
                if (gap_q <= 4'd1) begin
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            tx_data_q <= IDLE_D;
            tx_ctrl_q <= '1;
            grant_q   <= 2'b00;
            err_q     <= 1'b0;
            wcnt_q    <= '0;
            gap_q     <= '0;
            aborted_q <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_ctrl_q <= tx_ctrl_d;
            grant_q   <= grant_d;
            err_q     <= err_d;
            wcnt_q    <= wcnt_d;
            gap_q     <= gap_d;
            aborted_q <= aborted_d;
            rr_q      <= rr_d;
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_ctrl   = tx_ctrl_q;
    assign o_grant     = grant_q;
    assign o_frame_err = err_q;
endmodule

// File: tb/tb_mii_tx_arbiter.sv
// tb_mii_tx_arbiter: directed scoreboard bench for mii_tx_arbiter with MAX_WORDS=4.
module tb_mii_tx_arbiter;
    localparam int IPG = 2;
    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
    localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;

    typedef struct { logic [63:0] d; logic [7:0] c; logic e; logic [1:0] g; int gap; } exp_t;
    typedef struct { logic [63:0] d; logic l; int stall; } src_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] s0_data = '0, s1_data = '0;
    logic        s0_valid = 1'b0, s1_valid = 1'b0, s0_last = 1'b0, s1_last = 1'b0;
    logic        o_s0_ready, o_s1_ready, o_frame_err;
    logic [63:0] o_tx_data;
    logic [7:0]  o_tx_ctrl;
    logic [1:0]  o_grant;

    exp_t exp_q[$];
    src_t q0[$], q1[$];
    int   n_cmp = 0, n_bad = 0, idle_run = 0, rdy1_cnt = 0;

    mii_tx_arbiter #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .IPG_WORDS(IPG), .MAX_WORDS(4)) dut (
        .clk(clk), .i_rst_n(rst_n),
        .i_s0_data(s0_data), .i_s0_valid(s0_valid), .i_s0_last(s0_last),
        .i_s1_data(s1_data), .i_s1_valid(s1_valid), .i_s1_last(s1_last),
        .o_s0_ready(o_s0_ready), .o_s1_ready(o_s1_ready),
        .o_tx_data(o_tx_data), .o_tx_ctrl(o_tx_ctrl), .o_grant(o_grant), .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic ex(input logic [63:0] d, input logic [7:0] c, input logic e, input logic [1:0] g, input int gap);
        exp_q.push_back('{d, c, e, g, gap});
    endtask

    task automatic sp(input int s, input logic [7:0] b, input logic l, input int stall);
        if (s == 0) q0.push_back('{{8{b}}, l, stall});
        else q1.push_back('{{8{b}}, l, stall});
    endtask

    task automatic frame_ok(input int s, input logic [7:0] b, input logic [7:0] st, input int n, input int gap);
        logic [1:0] g;
        logic [7:0] v;
        g = (s == 0) ? 2'b01 : 2'b10;
        ex(START_W, 8'h01, 1'b0, g, gap);
        for (int i = 0; i < n; i++) begin
            v = b + st * 8'(i);
            sp(s, v, i == n - 1, 0);
            ex({8{v}}, 8'h00, 1'b0, g, -1);
        end
        ex(TERM_W, 8'hFF, 1'b0, g, -1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 80'(exp_q.size()), 80'(0));
        repeat (6) @(negedge clk);
    endtask

    // Source models: present queue head, pop on handshake, optional stall before a word
    initial begin
        bit hs;
        int st;
        st = 0;
        forever begin
            @(negedge clk);
            hs = s0_valid & o_s0_ready;
            @(posedge clk);
            #1;
            if (hs && q0.size() > 0) begin void'(q0.pop_front()); st = 0; end
            if (q0.size() > 0 && st < q0[0].stall) begin s0_valid = 1'b0; st++; end
            else if (q0.size() > 0) begin s0_valid = 1'b1; s0_data = q0[0].d; s0_last = q0[0].l; end
            else s0_valid = 1'b0;
        end
    end

    initial begin
        bit hs;
        int st;
        st = 0;
        forever begin
            @(negedge clk);
            hs = s1_valid & o_s1_ready;
            @(posedge clk);
            #1;
            if (hs && q1.size() > 0) begin void'(q1.pop_front()); st = 0; end
            if (q1.size() > 0 && st < q1[0].stall) begin s1_valid = 1'b0; st++; end
            else if (q1.size() > 0) begin s1_valid = 1'b1; s1_data = q1[0].d; s1_last = q1[0].l; end
            else s1_valid = 1'b0;
        end
    end

    // Wire monitor: every non-idle word must match the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_s1_ready) rdy1_cnt++;
            if (o_tx_data === IDLE_W && o_tx_ctrl === 8'hFF && o_frame_err === 1'b0) idle_run++;
            else if (exp_q.size() == 0) begin
                check("unexpected_word", {7'd0, o_frame_err, o_tx_ctrl, o_tx_data}, {7'd0, 1'b0, 8'hFF, IDLE_W});
                idle_run = 0;
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 80'(o_tx_data), 80'(e.d));
                check("tx_ctrl", 80'(o_tx_ctrl), 80'(e.c));
                check("frame_err", 80'(o_frame_err), 80'(e.e));
                check("grant", 80'(o_grant), 80'(e.g));
                if (o_tx_data === START_W) check("min_gap", 80'(idle_run >= IPG), 80'(1));
                if (e.gap >= 0) check("exact_gap", 80'(idle_run), 80'(e.gap));
                idle_run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check("rst_data", 80'(o_tx_data), 80'(IDLE_W));
        check("rst_ctrl", 80'(o_tx_ctrl), 80'(8'hFF));
        check("rst_grant", 80'(o_grant), 80'(0));
        check("rst_err", 80'(o_frame_err), 80'(0));
        check("rst_ready", 80'({o_s1_ready, o_s0_ready}), 80'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        frame_ok(0, 8'h11, 8'h11, 3, -1);
        wait_drain();

        rdy1_cnt = 0;
        frame_ok(1, 8'hAB, 8'h00, 1, -1);
        wait_drain();
        check("s1_ready_cycles", 80'(rdy1_cnt), 80'(1));

        for (int f = 0; f < 3; f++) begin
            frame_ok(0, 8'hA0 + 8'(f * 2), 8'h01, 2, (f == 0) ? -1 : IPG);
            frame_ok(1, 8'hB0 + 8'(f * 2), 8'h01, 2, IPG);
        end
        wait_drain();

        ex(START_W, 8'h01, 1'b0, 2'b10, -1);
        ex({8{8'hC1}}, 8'h00, 1'b0, 2'b10, -1);
        ex(ERR_W, 8'hFF, 1'b1, 2'b10, -1);
        ex(TERM_W, 8'hFF, 1'b0, 2'b10, -1);
        sp(1, 8'hC1, 1'b0, 0);
        sp(1, 8'hC2, 1'b0, 1);
        sp(1, 8'hC3, 1'b0, 0);
        sp(1, 8'hC4, 1'b1, 0);
        wait_drain();

        ex(START_W, 8'h01, 1'b0, 2'b01, -1);
        for (int i = 1; i <= 6; i++) begin
            sp(0, 8'hD0 + 8'(i), i == 6, 0);
            if (i <= 3) ex({8{8'hD0 + 8'(i)}}, 8'h00, 1'b0, 2'b01, -1);
        end
        ex(ERR_W, 8'hFF, 1'b1, 2'b01, -1);
        ex(TERM_W, 8'hFF, 1'b0, 2'b01, -1);
        wait_drain();

        frame_ok(1, 8'hE1, 8'h01, 4, -1);
        wait_drain();

        frame_ok(0, 8'h51, 8'h01, 4, -1);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            found = (o_tx_data === {8{8'h52}});
        end
        check("reached_word2", 80'(found), 80'(1));
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        q0.delete();
        s0_valid = 1'b0;
        #1;
        check("async_rst_data", 80'(o_tx_data), 80'(IDLE_W));
        check("async_rst_ctrl", 80'(o_tx_ctrl), 80'(8'hFF));
        check("async_rst_grant", 80'(o_grant), 80'(0));
        check("async_rst_ready", 80'({o_s1_ready, o_s0_ready}), 80'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame_ok(0, 8'h61, 8'h00, 1, -1);
        frame_ok(1, 8'h71, 8'h00, 1, IPG);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mii_tx_arbiter.md
MII_TX_ARBITER -- requirements
Module: mii_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 64, width of MII data word; byte n = bits [8n+7:8n].
REQ-002 Parameter CTRL_WIDTH, 8, one control bit per data byte (1 = control character).
REQ-003 Parameter IPG_WORDS, 2, minimum idle words after a terminate word (range 1..15).
REQ-004 Parameter MAX_WORDS, 190, maximum payload words per frame (range 2..255).
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-007 i_s0_data / i_s1_data  in  DATA_WIDTH  payload word from source 0 / 1.
REQ-008 i_s0_valid / i_s1_valid  in  1  source has a word (or frame) pending.
REQ-009 i_s0_last / i_s1_last  in  1  current word is the final payload word of the frame.
REQ-010 o_s0_ready / o_s1_ready  out  1  word accepted this cycle when valid & ready (combinational from state and grant).
REQ-011 o_tx_data  out  DATA_WIDTH  registered MII data.
REQ-012 o_tx_ctrl  out  CTRL_WIDTH  registered MII control.
REQ-013 o_grant  out  2  one-hot owner of the current frame; 2'b00 when none.
REQ-014 o_frame_err  out  1  one-cycle pulse, registered, coincident with an error word on o_tx_data.

Function
REQ-015 Encodings SHALL be: IDLE data 0x0707070707070707 ctrl 0xFF; START data 0xD5555555555555FB ctrl 0x01; DATA ctrl 0x00; TERM data 0x07070707070707FD ctrl 0xFF; ERROR data 0xFEFEFEFEFEFEFEFE ctrl 0xFF.
REQ-016 State machine SHALL have states IDLE, DATA, TERM, FLUSH, IPG; o_tx_data/o_tx_ctrl SHALL be IDLE in every cycle not listed below.
REQ-017 IDLE: if any valid high, arbiter SHALL grant one source, register START onto the output next edge, set o_grant, clear word count, go DATA; ready SHALL be 0 in IDLE.
REQ-018 Arbitration SHALL be round-robin: single requester wins; both requesting -> source not granted last; after reset source 0 wins a tie.
REQ-019 DATA: ready SHALL be 1 for the granted source only; on valid & ready the word SHALL be registered with ctrl 0x00 and word count incremented (8-bit, saturating).
REQ-020 DATA, valid & last accepted -> go TERM; TERM word SHALL appear on the output the cycle after the last data word.
REQ-021 DATA, granted valid low (underrun) -> register ERROR, pulse o_frame_err, mark frame aborted, go TERM.
REQ-022 DATA, word accepted as number MAX_WORDS with last low (oversize) -> register ERROR in place of that word, pulse o_frame_err, mark aborted, go TERM.
REQ-023 TERM: register TERM word; aborted -> FLUSH, else -> IPG with gap counter loaded to IPG_WORDS; ready 0.
REQ-024 FLUSH: ready 1 for granted source, accepted words SHALL be discarded, output IDLE; valid & last accepted -> IPG (loaded IPG_WORDS-1, FLUSH cycles count as gap, at least 1 further idle).
REQ-025 IPG: output IDLE, ready 0, decrement counter; at 0 -> IDLE, o_grant cleared; arbitration SHALL not occur before IPG_WORDS idle words follow any TERM.
REQ-026 Changes on the non-granted source's valid/data SHALL never affect the current frame.
REQ-027 Minimum frame on the wire: START, 1 DATA, TERM; one-word frame (valid & last on first beat) SHALL be legal.
REQ-028 Round-robin pointer SHALL update only at grant time in IDLE.

Reset
REQ-029 While i_rst_n low: state IDLE, o_tx_data/o_tx_ctrl IDLE encoding, o_grant 0, o_frame_err 0, ready 0, counters 0, RR pointer favouring source 0.
REQ-030 Reset asserted mid-frame SHALL abort immediately without emitting TERM; after release the block SHALL start in IDLE with no gap wait.

Verification
REQ-031 s0 sends 3 words 0x11..11, 0x22..22, 0x33..33 (last on 3rd) -> START, three DATA ctrl 0x00, TERM, then >=2 IDLE; o_grant 2'b01.
REQ-032 s0 and s1 both valid continuously with 2-word frames -> grants alternate 01,10,01,...; exactly IPG_WORDS IDLE between TERM and next START.
REQ-033 s1 valid drops after 1st word of a 4-word frame -> START, DATA, ERROR with o_frame_err=1, TERM, FLUSH drains remaining 3 words, then IPG.
REQ-034 MAX_WORDS=4, s0 sends 6 words -> START, 3 DATA, ERROR, TERM; words 5-6 flushed; o_frame_err pulses once.
REQ-035 Reset pulsed during 2nd DATA word -> outputs IDLE/0x07.., ctrl 0xFF asynchronously; next frame after release starts with START, s0 wins tie.
REQ-036 One-word frame from s1 with s0 idle -> START, DATA, TERM, IDLE x2; o_s1_ready high exactly one cycle.
